// File: rtl/gray_wptr_full.sv
// Write-domain pointer logic for an async FIFO: binary write counter, registered
// Gray write pointer, zero-latency full flag, pessimistic fill level and overflow pulse.

module gray_to_binary #(
    parameter int BITSIZE = 5
) (
    input  logic [BITSIZE-1:0] i_gray,
    output logic [BITSIZE-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at and above its position.
    for (genvar g = 0; g < BITSIZE; g++) begin : g_bit
        assign o_bin[g] = ^i_gray[BITSIZE-1:g];
    end

endmodule

module gray_wptr_full #(
    parameter int ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic [ADDRSIZE:0]   rptr_sync,
    output logic [ADDRSIZE-1:0] addr,
    output logic [ADDRSIZE:0]   ptr,
    output logic                full,
    output logic [ADDRSIZE:0]   level,
    output logic                overflow
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_ptr;
    logic          r_full;
    logic [PW-1:0] r_level;
    logic          r_overflow;

    logic          w_accept;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_full_target;
    logic          w_full_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_next;
    logic          w_overflow_next;

    gray_to_binary #(
        .BITSIZE (PW)
    ) u_rptr_decode (
        .i_gray (rptr_sync),
        .o_bin  (w_rbin)
    );

    // Acceptance uses the registered full so a rejected write leaves all state untouched.
    assign w_accept        = inc & ~r_full;
    assign w_bin_next      = r_bin + {{ADDRSIZE{1'b0}}, w_accept};
    assign w_gray_next     = w_bin_next ^ (w_bin_next >> 1);
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign w_full_target   = {~rptr_sync[ADDRSIZE], ~rptr_sync[ADDRSIZE-1], rptr_sync[ADDRSIZE-2:0]};
    assign w_full_next     = (w_gray_next == w_full_target);
    assign w_level_next    = w_bin_next - w_rbin;
    assign w_overflow_next = inc & r_full;

    // Pointer, flag and level registers; all outputs come straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= {PW{1'b0}};
            r_ptr      <= {PW{1'b0}};
            r_full     <= 1'b0;
            r_level    <= {PW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_bin      <= w_bin_next;
            r_ptr      <= w_gray_next;
            r_full     <= w_full_next;
            r_level    <= w_level_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign addr     = r_bin[ADDRSIZE-1:0];
    assign ptr      = r_ptr;
    assign full     = r_full;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_gray_wptr_full.sv
// Bench for gray_wptr_full (ADDRSIZE = 4): scenario tasks plus a scoreboard
// that holds per-cycle expectations from an independent behavioural model.

module tb_gray_wptr_full;

    localparam int A = 4;

    logic         clk;
    logic         rst_n;
    logic         inc;
    logic [A:0]   rptr_sync;
    logic [A-1:0] addr;
    logic [A:0]   ptr;
    logic         full;
    logic [A:0]   level;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] ptr;
        logic [3:0] addr;
        logic       full;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    // Behavioural model state
    logic [4:0] m_bin;
    logic       m_full;
    int         m_rd;

    gray_wptr_full #(.ADDRSIZE(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .rptr_sync (rptr_sync),
        .addr      (addr),
        .ptr       (ptr),
        .full      (full),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] from_gray(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Scoreboard: compare one expectation per clock edge, shortly after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (ptr !== e.ptr) begin
                errors++;
                $display("FAIL sb_ptr t=%0t got=%b exp=%b", $time, ptr, e.ptr);
            end
            checks++;
            if (addr !== e.addr) begin
                errors++;
                $display("FAIL sb_addr t=%0t got=%0d exp=%0d", $time, addr, e.addr);
            end
            checks++;
            if (full !== e.full) begin
                errors++;
                $display("FAIL sb_full t=%0t got=%b exp=%b", $time, full, e.full);
            end
            checks++;
            if (level !== e.level) begin
                errors++;
                $display("FAIL sb_level t=%0t got=%0d exp=%0d", $time, level, e.level);
            end
            checks++;
            if (overflow !== e.ovf) begin
                errors++;
                $display("FAIL sb_overflow t=%0t got=%b exp=%b", $time, overflow, e.ovf);
            end
        end
    end

    task automatic model_reset();
        m_bin  = 5'd0;
        m_full = 1'b0;
        m_rd   = 0;
    endtask

    // Drive one cycle, push the modelled result, return 2 time units after the edge.
    task automatic cycle(input logic i_inc, input logic [4:0] i_rptr);
        exp_t x;
        logic [4:0] rbin;
        logic [4:0] lvl;
        @(negedge clk);
        inc       = i_inc;
        rptr_sync = i_rptr;
        x.ovf  = i_inc & m_full;
        if (i_inc && !m_full) m_bin = m_bin + 5'd1;
        rbin   = from_gray(i_rptr);
        lvl    = m_bin - rbin;
        m_full = (lvl == 5'd16);
        x.ptr   = to_gray(m_bin);
        x.addr  = m_bin[3:0];
        x.full  = m_full;
        x.level = lvl;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inc   = 1'b0;
        rptr_sync = 5'd0;
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rptr_sync = 5'd0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            inc = k[0];
        end
        @(posedge clk);
        #1;
        checks++;
        if ({addr, ptr, full, level, overflow} !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold got addr=%0d ptr=%b full=%b level=%0d ovf=%b exp all zero",
                     addr, ptr, full, level, overflow);
        end
        @(negedge clk);
        inc   = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [4:0] seq [0:3];
        seq[0] = 5'b00001; seq[1] = 5'b00011; seq[2] = 5'b00010; seq[3] = 5'b00110;
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, 5'd0);
            if (k < 4) begin
                checks++;
                if (ptr !== seq[k]) begin
                    errors++;
                    $display("FAIL fill_ptr_step%0d got=%b exp=%b", k, ptr, seq[k]);
                end
            end
            if (k == 14) begin
                checks++;
                if (full !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_not_full_at15 got=%b exp=0", full);
                end
            end
        end
        checks++;
        if (ptr !== 5'b11000 || full !== 1'b1 || level !== 5'd16 || addr !== 4'd0) begin
            errors++;
            $display("FAIL fill_final got ptr=%b full=%b level=%0d addr=%0d exp 11000/1/16/0",
                     ptr, full, level, addr);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 5'd0);
            checks++;
            if (overflow !== 1'b1 || ptr !== 5'b11000 || addr !== 4'd0 || level !== 5'd16) begin
                errors++;
                $display("FAIL overflow_%0d got ovf=%b ptr=%b addr=%0d level=%0d exp 1/11000/0/16",
                         k, overflow, ptr, addr, level);
            end
        end
        cycle(1'b0, 5'd0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_drain();
        cycle(1'b0, 5'b00010);
        checks++;
        if (full !== 1'b0 || level !== 5'd13 || ptr !== 5'b11000) begin
            errors++;
            $display("FAIL drain got full=%b level=%0d ptr=%b exp 0/13/11000", full, level, ptr);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 16; k++) cycle(1'b1, 5'd0);
        cycle(1'b1, 5'b00001);
        checks++;
        if (overflow !== 1'b1 || ptr !== 5'b11000 || full !== 1'b0 || level !== 5'd15) begin
            errors++;
            $display("FAIL simul_reject got ovf=%b ptr=%b full=%b level=%0d exp 1/11000/0/15",
                     overflow, ptr, full, level);
        end
        cycle(1'b1, 5'b00001);
        checks++;
        if (ptr !== 5'b11001 || full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_refill got ptr=%b full=%b ovf=%b exp 11001/1/0", ptr, full, overflow);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 31; k++) cycle(1'b1, to_gray(m_bin));
        checks++;
        if (ptr !== 5'b10000 || addr !== 4'd15) begin
            errors++;
            $display("FAIL wrap_pre got ptr=%b addr=%0d exp 10000/15", ptr, addr);
        end
        cycle(1'b1, 5'b11110);
        checks++;
        if (ptr !== 5'b00000 || addr !== 4'd0 || level !== 5'd12 || full !== 1'b0) begin
            errors++;
            $display("FAIL wrap got ptr=%b addr=%0d level=%0d full=%b exp 00000/0/12/0",
                     ptr, addr, level, full);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            if (((m_bin - m_rd[4:0]) & 5'h1f) != 5'd0 && $urandom_range(0, 2) == 0) m_rd++;
            rd = m_rd[4:0];
            cycle($urandom_range(0, 3) != 0, to_gray(rd));
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 5'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({addr, ptr, full, level, overflow} !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got addr=%0d ptr=%b full=%b level=%0d ovf=%b exp all zero",
                     addr, ptr, full, level, overflow);
        end
        sb_q.delete();
        model_reset();
        inc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        inc       = 1'b0;
        rptr_sync = 5'd0;
        rst_n     = 1'b0;
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_random();
        test_async_reset();
        test_fill();
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
